// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: FSM states, access sizes
// and the func3 codes for every load and store flavour.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Codes not listed fall through to a full word.
  function automatic size_t size_of(input logic [2:0] fun3);
    case (fun3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input size_t sz);
    case (sz)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: byte mask, beat split decision, store data
// placement and load data extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  fun3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] slot0,
  input  logic [31:0] slot1,
  output logic [7:0]  mask8,
  output logic        two_beats,
  output logic [63:0] store64,
  output logic [31:0] load_data
);

  logic [4:0]  sh;
  logic [31:0] raw;

  assign sh        = {offset, 3'b000};
  assign mask8     = {4'b0000, size_mask(size_of(fun3))} << offset;
  assign two_beats = |mask8[7:4];
  assign store64   = {32'h0000_0000, wdata} << sh;

  // The two beats form one 64-bit window; the access starts at byte offset.
  assign raw = 32'({slot1, slot0} >> sh);

  always_comb begin
    load_data = raw;
    case (fun3)
      F3_LB:   load_data = {{24{raw[7]}}, raw[7:0]};
      F3_LH:   load_data = {{16{raw[15]}}, raw[15:0]};
      F3_LBU:  load_data = {24'h000000, raw[7:0]};
      F3_LHU:  load_data = {16'h0000, raw[15:0]};
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a variable-latency data
// memory port; splits word-crossing accesses into two aligned beats.
//
// state | meaning
// IDLE  | waiting for a request; captures it and issues beat 0
// REQ0  | beat 0 request held until accepted
// WAIT0 | load beat 0 waiting for read data
// REQ1  | beat 1 request held until accepted
// WAIT1 | load beat 1 waiting for read data
// DONE  | completion pulse, stall released
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread_MEM,
  input  logic              memwrite_MEM,
  input  logic [2:0]        fun3_MEM,
  input  logic [ADDR_W-1:0] addr_MEM,
  input  logic [31:0]       writedata_MEM,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       readdata_o,
  output logic              dm_req_o,
  input  logic              dm_ready_i,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [3:0]        dm_we_o,
  output logic [31:0]       dm_wdata_o,
  input  logic              dm_rvalid_i,
  input  logic [31:0]       dm_rdata_i
);

  state_t state;

  logic              is_load;
  logic [2:0]        fun3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       slot0;
  logic [31:0]       slot1;

  logic [2:0]        sel_fun3;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [31:0]       ld_slot0;
  logic [31:0]       ld_slot1;
  logic [ADDR_W-1:0] beat0_addr;
  logic [ADDR_W-1:0] beat1_addr;
  logic [7:0]        mask8;
  logic              two_beats;
  logic [63:0]       store64;
  logic [31:0]       load_data;

  // In IDLE the first beat is built straight from the live MEM-stage inputs.
  assign sel_fun3  = (state == ST_IDLE) ? fun3_MEM      : fun3_q;
  assign sel_addr  = (state == ST_IDLE) ? addr_MEM      : addr_q;
  assign sel_wdata = (state == ST_IDLE) ? writedata_MEM : wdata_q;

  // Returning data is folded in before it is latched so DONE sees the result.
  assign ld_slot0 = (state == ST_WAIT0) ? dm_rdata_i : slot0;
  assign ld_slot1 = (state == ST_WAIT1) ? dm_rdata_i : slot1;

  assign beat0_addr = {sel_addr[ADDR_W-1:2], 2'b00};
  assign beat1_addr = beat0_addr + ADDR_W'(4);

  assign stall_o = (memread_MEM | memwrite_MEM) & (state != ST_DONE);

  lsu_align u_align (
    .fun3      (sel_fun3),
    .offset    (sel_addr[1:0]),
    .wdata     (sel_wdata),
    .slot0     (ld_slot0),
    .slot1     (ld_slot1),
    .mask8     (mask8),
    .two_beats (two_beats),
    .store64   (store64),
    .load_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      is_load    <= 1'b0;
      fun3_q     <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      slot0      <= 32'h0;
      slot1      <= 32'h0;
      dm_req_o   <= 1'b0;
      dm_addr_o  <= '0;
      dm_we_o    <= 4'b0000;
      dm_wdata_o <= 32'h0;
      done_o     <= 1'b0;
      readdata_o <= 32'h0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (memread_MEM | memwrite_MEM) begin
            is_load    <= memread_MEM;
            fun3_q     <= fun3_MEM;
            addr_q     <= addr_MEM;
            wdata_q    <= writedata_MEM;
            dm_req_o   <= 1'b1;
            dm_addr_o  <= beat0_addr;
            dm_we_o    <= memread_MEM ? 4'b0000 : mask8[3:0];
            dm_wdata_o <= memread_MEM ? 32'h0 : store64[31:0];
            state      <= ST_REQ0;
          end
        end
        ST_REQ0: begin
          if (dm_ready_i) begin
            if (is_load) begin
              dm_req_o <= 1'b0;
              state    <= ST_WAIT0;
            end else if (two_beats) begin
              dm_addr_o  <= beat1_addr;
              dm_we_o    <= mask8[7:4];
              dm_wdata_o <= store64[63:32];
              state      <= ST_REQ1;
            end else begin
              dm_req_o <= 1'b0;
              done_o   <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_WAIT0: begin
          if (dm_rvalid_i) begin
            slot0 <= dm_rdata_i;
            if (two_beats) begin
              dm_req_o   <= 1'b1;
              dm_addr_o  <= beat1_addr;
              dm_we_o    <= 4'b0000;
              dm_wdata_o <= 32'h0;
              state      <= ST_REQ1;
            end else begin
              readdata_o <= load_data;
              done_o     <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        ST_REQ1: begin
          if (dm_ready_i) begin
            dm_req_o <= 1'b0;
            if (is_load) begin
              state <= ST_WAIT1;
            end else begin
              done_o <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_WAIT1: begin
          if (dm_rvalid_i) begin
            slot1      <= dm_rdata_i;
            readdata_o <= load_data;
            done_o     <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table of single/two-beat accesses plus
// hand-written back-pressure and mid-access reset sequences.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [2:0]  fun3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] readdata;
  logic        dm_req;
  logic        dm_ready;
  logic [31:0] dm_addr;
  logic [3:0]  dm_we;
  logic [31:0] dm_wdata;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] last_ld = 32'h0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .memread_MEM   (memread),
    .memwrite_MEM  (memwrite),
    .fun3_MEM      (fun3),
    .addr_MEM      (addr),
    .writedata_MEM (wdata),
    .stall_o       (stall),
    .done_o        (done),
    .readdata_o    (readdata),
    .dm_req_o      (dm_req),
    .dm_ready_i    (dm_ready),
    .dm_addr_o     (dm_addr),
    .dm_we_o       (dm_we),
    .dm_wdata_o    (dm_wdata),
    .dm_rvalid_i   (dm_rvalid),
    .dm_rdata_i    (dm_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] r0;
    logic [31:0] r1;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  we0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  we1;
    logic [31:0] wd1;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  beat;
    bit  pend;
    bit  done_seen;
    int  exp_cyc;
    beat = 0;
    pend = 0;
    done_seen = 0;
    exp_cyc = v.rd ? 1 + 2 * v.nb : 1 + v.nb;
    @(negedge clk);
    memread  = v.rd;
    memwrite = v.wr;
    fun3     = v.f3;
    addr     = v.addr;
    wdata    = v.wdata;
    dm_ready = 1'b1;
    dm_rvalid = 1'b0;
    #1;
    chk($sformatf("v%0d.capture_stall", idx), 32'(stall), 32'd1);
    for (int c = 1; c <= 20 && !done_seen; c++) begin
      @(negedge clk);
      dm_rvalid = 1'b0;
      if (done) begin
        done_seen = 1;
        chk($sformatf("v%0d.latency", idx), c, exp_cyc);
        chk($sformatf("v%0d.beats", idx), beat, v.nb);
        chk($sformatf("v%0d.done_stall", idx), 32'(stall), 32'd0);
        if (v.rd) begin
          chk($sformatf("v%0d.readdata", idx), readdata, v.res);
          last_ld = v.res;
        end else begin
          chk($sformatf("v%0d.readdata_held", idx), readdata, last_ld);
        end
        memread  = 1'b0;
        memwrite = 1'b0;
      end else begin
        if (pend) begin
          dm_rvalid = 1'b1;
          dm_rdata  = (beat == 1) ? v.r0 : v.r1;
          pend = 0;
        end
        if (dm_req) begin
          chk($sformatf("v%0d.addr%0d", idx, beat), dm_addr, (beat == 0) ? v.a0 : v.a1);
          chk($sformatf("v%0d.we%0d", idx, beat), 32'(dm_we), 32'((beat == 0) ? v.we0 : v.we1));
          if (!v.rd)
            chk($sformatf("v%0d.wdata%0d", idx, beat), dm_wdata, (beat == 0) ? v.wd0 : v.wd1);
          beat++;
          if (v.rd) pend = 1;
        end
      end
    end
    if (!done_seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL v%0d.timeout: no done_o within 20 cycles", idx);
      memread  = 1'b0;
      memwrite = 1'b0;
    end
  endtask

  initial begin
    int acc;
    int pulses;

    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1,
                 32'h100, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 32'h0, 1,
                 32'h100, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 32'h0, 1,
                 32'h100, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00000080};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h203, 32'h1234, 32'h0, 32'h0, 2,
                 32'h200, 4'b1000, 32'h34000000, 32'h204, 4'b0001, 32'h00000012, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h202, 32'h0, 32'h55667788, 32'h11223344, 2,
                 32'h200, 4'h0, 32'h0, 32'h204, 4'h0, 32'h0, 32'h33445566};
    vecs[5]  = '{1'b0, 1'b1, 3'b010, 32'h300, 32'hA1B2C3D4, 32'h0, 32'h0, 1,
                 32'h300, 4'b1111, 32'hA1B2C3D4, 32'h0, 4'h0, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h301, 32'h123456EF, 32'h0, 32'h0, 1,
                 32'h300, 4'b0010, 32'h3456EF00, 32'h0, 4'h0, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 32'h0, 1,
                 32'h100, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF8001};
    vecs[8]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 32'h0, 1,
                 32'h100, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00008001};
    vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h401, 32'hA1B2C3D4, 32'h0, 32'h0, 2,
                 32'h400, 4'b1110, 32'hB2C3D400, 32'h404, 4'b0001, 32'h000000A1, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0FF, 32'h0, 32'hAB000000, 32'h000000CD, 2,
                 32'h0FC, 4'h0, 32'h0, 32'h100, 4'h0, 32'h0, 32'hFFFFCDAB};
    vecs[11] = '{1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'hBEEF1111, 32'h2222CAFE, 2,
                 32'hFFFFFFFC, 4'h0, 32'h0, 32'h00000000, 4'h0, 32'h0, 32'hCAFEBEEF};
    vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h12345678, 32'h0, 1,
                 32'h100, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h12345678};
    vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h500, 32'hFFFFFFFF, 32'h0BADF00D, 32'h0, 1,
                 32'h500, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0BADF00D};

    rst = 1'b1;
    memread = 1'b0;
    memwrite = 1'b0;
    fun3 = 3'b000;
    addr = 32'h0;
    wdata = 32'h0;
    dm_ready = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.req", 32'(dm_req), 32'd0);
    chk("rst.addr", dm_addr, 32'h0);
    chk("rst.we", 32'(dm_we), 32'd0);
    chk("rst.wdata", dm_wdata, 32'h0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.readdata", readdata, 32'h0);
    chk("rst.stall", 32'(stall), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Back-pressure: request held five cycles in REQ0, then accepted once.
    @(negedge clk);
    @(negedge clk);
    memwrite = 1'b1;
    fun3 = 3'b010;
    addr = 32'h600;
    wdata = 32'hCAFEF00D;
    dm_ready = 1'b0;
    #1;
    chk("bp.capture_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp.req%0d", i), 32'(dm_req), 32'd1);
      chk($sformatf("bp.addr%0d", i), dm_addr, 32'h600);
      chk($sformatf("bp.we%0d", i), 32'(dm_we), 32'hF);
      chk($sformatf("bp.wdata%0d", i), dm_wdata, 32'hCAFEF00D);
      chk($sformatf("bp.stall%0d", i), 32'(stall), 32'd1);
    end
    @(negedge clk);
    dm_ready = 1'b1;
    acc = (dm_req && dm_ready) ? 1 : 0;
    @(negedge clk);
    if (dm_req && dm_ready) acc++;
    chk("bp.done", 32'(done), 32'd1);
    chk("bp.stall_done", 32'(stall), 32'd0);
    chk("bp.readdata_held", readdata, last_ld);
    memwrite = 1'b0;
    @(negedge clk);
    if (dm_req && dm_ready) acc++;
    chk("bp.accepts", acc, 1);

    // Reset while waiting for beat-0 read data; late rvalid must be ignored.
    @(negedge clk);
    memread = 1'b1;
    fun3 = 3'b010;
    addr = 32'h700;
    dm_ready = 1'b1;
    @(negedge clk);
    chk("rw.req0", 32'(dm_req), 32'd1);
    @(negedge clk);
    chk("rw.wait0_req", 32'(dm_req), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    memread = 1'b0;
    chk("rw.req", 32'(dm_req), 32'd0);
    chk("rw.addr", dm_addr, 32'h0);
    chk("rw.readdata", readdata, 32'h0);
    dm_rvalid = 1'b1;
    dm_rdata = 32'h99999999;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dm_rvalid = 1'b0;
      if (done) pulses++;
    end
    chk("rw.done_pulses", pulses, 0);
    chk("rw.readdata_after", readdata, 32'h0);
    chk("rw.req_after", 32'(dm_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
